corelet_ctrl: RTL and testbench

Sequencer for the corelet datapath. It runs one complete job (weight load, execution and psum drain) in either weight-stationary (WS) or output-stationary (OS) mode. It sits between the activation/weight SRAM, the psum SRAM and the corelet. It generates every L0, IFIFO, `inst` and OFIFO strobe, and all SRAM addresses, from a single start pulse. Row, column, job length and address widths are parameters.

---
 rtl/corelet_pkg.sv | 19 +
 rtl/stream_feeder.sv | 58 +++++
 rtl/corelet_ctrl.sv | 150 +++++++++++++++
 tb/tb_corelet_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/corelet_pkg.sv
// Shared state encoding and MAC-array instruction codes for the corelet sequencer.
package corelet_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOADW   = 3'd1,
        S_WFLUSH  = 3'd2,
        S_EXEC    = 3'd3,
        S_OSDRAIN = 3'd4,
        S_DRAIN   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // inst = {execute, load}
    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/stream_feeder.sv
// SRAM-to-FIFO stream: issues reads at base+k, tracks the vector in flight and
// the one-entry skid register, and strobes the write into the target FIFO.
module stream_feeder #(
    parameter int cnt_w   = 9,
    parameter int addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,       // phase active; all state clears while low
    input  logic [cnt_w-1:0]   total,    // vectors to move in this phase
    input  logic [addr_bw-1:0] base,
    input  logic               full,
    output logic               rd_en,
    output logic [addr_bw-1:0] rd_addr,
    output logic               wr,
    output logic [cnt_w-1:0]   wr_cnt
);

    logic [cnt_w-1:0] rd_cnt_q, rd_cnt_d;
    logic [cnt_w-1:0] wr_cnt_q, wr_cnt_d;
    logic             inflight_q, inflight_d;   // read issued last cycle, data on the bus now
    logic             skid_q, skid_d;           // data parked because full rose while in flight

    // Strobes and next state: a held vector blocks new reads until it has been written
    always_comb begin
        rd_en      = en && !full && !skid_q && (rd_cnt_q < total);
        wr         = en && !full && (inflight_q || skid_q);
        rd_addr    = rd_en ? base + addr_bw'(rd_cnt_q) : '0;
        rd_cnt_d   = rd_cnt_q + cnt_w'(rd_en);
        wr_cnt_d   = wr_cnt_q + cnt_w'(wr);
        inflight_d = rd_en;
        skid_d     = (inflight_q || skid_q) && full;
        if (!en) begin
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
            inflight_d = 1'b0;
            skid_d     = 1'b0;
        end
    end

    // Counter and skid registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            inflight_q <= 1'b0;
            skid_q     <= 1'b0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            inflight_q <= inflight_d;
            skid_q     <= skid_d;
        end
    end

    assign wr_cnt = wr_cnt_q;

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet job sequencer: weight load, execution and psum drain in WS or OS mode,
// generating every SRAM address and corelet strobe from a single start pulse.
module corelet_ctrl #(
    parameter int row         = 8,
    parameter int col         = 8,
    parameter int len_bw      = 8,
    parameter int addr_bw     = 11,
    parameter int ififo_depth = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               os_en,
    input  logic [len_bw-1:0]  n_vec,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] x_base,
    input  logic [addr_bw-1:0] p_base,
    input  logic               l0_full,
    input  logic               ififo_full,
    input  logic               ofifo_valid,
    output logic               sram_rd_en,
    output logic [addr_bw-1:0] sram_addr,
    output logic               l0_wr,
    output logic               l0_rd,
    output logic               ififo_wr,
    output logic               ififo_rd,
    output logic               ofifo_rd,
    output logic [1:0]         inst,
    output logic               os_en_q,
    output logic               psum_wr_en,
    output logic [addr_bw-1:0] psum_addr,
    output logic               busy,
    output logic               done
);
    import corelet_pkg::*;

    localparam int CW = len_bw + 1;

    state_t             state_q, state_d;
    logic               os_en_d;
    logic [CW-1:0]      nvec_q, nvec_d;
    logic [addr_bw-1:0] w_base_q, w_base_d, x_base_q, x_base_d, p_base_q, p_base_d;
    logic [CW-1:0]      cnt_q, cnt_d;   // per-phase: L0 reads, flush cycles or psum pops

    logic               ld_ws, ld_os, in_exec, l0f_en, cnt_inc;
    logic               l0f_rd, l0f_wr, iff_rd, iff_wr;
    logic [CW-1:0]      l0f_total, l0f_wr_cnt, iff_wr_cnt, drain_tgt;
    logic [addr_bw-1:0] l0f_base, l0f_addr, iff_addr;

    assign ld_ws     = (state_q == S_LOADW) && !os_en_q && (nvec_q != '0);
    assign ld_os     = (state_q == S_LOADW) &&  os_en_q && (nvec_q != '0);
    assign in_exec   = (state_q == S_EXEC);
    assign l0f_en    = ld_ws || in_exec;
    assign l0f_total = ld_ws ? CW'(col) : nvec_q;
    assign l0f_base  = ld_ws ? w_base_q : x_base_q;
    assign drain_tgt = os_en_q ? CW'(row) : nvec_q;

    // L0 path: weights in WS load, activations in execution
    stream_feeder #(.cnt_w(CW), .addr_bw(addr_bw)) u_l0_feed (
        .clk(clk), .reset(reset), .en(l0f_en), .total(l0f_total), .base(l0f_base),
        .full(l0_full), .rd_en(l0f_rd), .rd_addr(l0f_addr), .wr(l0f_wr), .wr_cnt(l0f_wr_cnt)
    );

    // IFIFO path: weights in OS load
    stream_feeder #(.cnt_w(CW), .addr_bw(addr_bw)) u_if_feed (
        .clk(clk), .reset(reset), .en(ld_os), .total(nvec_q), .base(w_base_q),
        .full(ififo_full), .rd_en(iff_rd), .rd_addr(iff_addr), .wr(iff_wr), .wr_cnt(iff_wr_cnt)
    );

    // Only one feeder is enabled at a time, so the SRAM port is a plain OR
    assign sram_rd_en = l0f_rd | iff_rd;
    assign sram_addr  = l0f_addr | iff_addr;
    assign l0_wr      = l0f_wr;
    assign ififo_wr   = iff_wr;

    // L0 is read only once a written vector is waiting in it
    assign l0_rd      = l0f_en && (cnt_q < l0f_wr_cnt);
    assign ififo_rd   = in_exec && os_en_q && l0_rd;
    assign ofifo_rd   = (state_q == S_DRAIN) && ofifo_valid && (cnt_q != drain_tgt);
    assign psum_wr_en = ofifo_rd;
    assign psum_addr  = ofifo_rd ? p_base_q + addr_bw'(cnt_q) : '0;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);

    // MAC-array instruction: tied to each L0 read, held during the flush windows
    always_comb begin
        inst = INST_IDLE;
        if (ld_ws && l0_rd)             inst = INST_LOAD;
        else if (in_exec && l0_rd)      inst = INST_EXEC;
        else if (state_q == S_OSDRAIN)  inst = INST_LOAD;
    end

    // Next state, job latching and the shared phase counter
    always_comb begin
        state_d  = state_q;
        os_en_d  = os_en_q;
        nvec_d   = nvec_q;
        w_base_d = w_base_q;
        x_base_d = x_base_q;
        p_base_d = p_base_q;
        cnt_inc  = l0_rd || ofifo_rd || (state_q == S_WFLUSH) || (state_q == S_OSDRAIN);
        case (state_q)
            S_IDLE: if (start) begin
                os_en_d  = os_en;
                nvec_d   = {1'b0, n_vec};
                w_base_d = w_base;
                x_base_d = x_base;
                p_base_d = p_base;
                // an OS job longer than the IFIFO cannot be held and is refused
                state_d  = (os_en && ({1'b0, n_vec} > CW'(ififo_depth))) ? S_DONE : S_LOADW;
            end
            S_LOADW: begin
                if (nvec_q == '0)                       state_d = S_DONE;
                else if (os_en_q && iff_wr_cnt == nvec_q) state_d = S_EXEC;
                else if (!os_en_q && cnt_q == CW'(col))   state_d = S_WFLUSH;
            end
            S_WFLUSH:  if (cnt_q == CW'(row + col - 1)) state_d = S_EXEC;
            S_EXEC:    if (cnt_q == nvec_q) state_d = os_en_q ? S_OSDRAIN : S_DRAIN;
            S_OSDRAIN: if (cnt_q == CW'(row - 1)) state_d = S_DRAIN;
            S_DRAIN:   if (cnt_q == drain_tgt) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
        else if (cnt_inc)       cnt_d = cnt_q + CW'(1);
        else                    cnt_d = cnt_q;
    end

    // Sequencer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            os_en_q  <= 1'b0;
            nvec_q   <= '0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            os_en_q  <= os_en_d;
            nvec_q   <= nvec_d;
            w_base_q <= w_base_d;
            x_base_q <= x_base_d;
            p_base_q <= p_base_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl: table of directed jobs, random jobs with backpressure,
// and hand sequences for reset-in-drain. Expectations come from a job-level model.
module tb_corelet_ctrl;
    localparam int ROW = 8, COL = 8, LBW = 8, ABW = 11, DEPTH = 128;
    localparam int AMOD = 1 << ABW;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, os_en = 1'b0;
    logic [LBW-1:0] n_vec = '0;
    logic [ABW-1:0] w_base = '0, x_base = '0, p_base = '0;
    logic l0_full = 1'b0, ififo_full = 1'b0, ofifo_valid = 1'b0;
    logic sram_rd_en, l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd, os_en_q, psum_wr_en, busy, done;
    logic [ABW-1:0] sram_addr, psum_addr;
    logic [1:0] inst;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    corelet_ctrl #(.row(ROW), .col(COL), .len_bw(LBW), .addr_bw(ABW), .ififo_depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .os_en(os_en), .n_vec(n_vec),
        .w_base(w_base), .x_base(x_base), .p_base(p_base),
        .l0_full(l0_full), .ififo_full(ififo_full), .ofifo_valid(ofifo_valid),
        .sram_rd_en(sram_rd_en), .sram_addr(sram_addr), .l0_wr(l0_wr), .l0_rd(l0_rd),
        .ififo_wr(ififo_wr), .ififo_rd(ififo_rd), .ofifo_rd(ofifo_rd), .inst(inst),
        .os_en_q(os_en_q), .psum_wr_en(psum_wr_en), .psum_addr(psum_addr),
        .busy(busy), .done(done)
    );

    typedef struct {
        bit os; int nv; int wb; int xb; int pb; int bp; bit poke;
        int done_cyc; int psum_n;   // expected; -1 = not checked
    } vec_t;

    vec_t tbl[8];

    // model expectations
    int exp_rd[$], exp_ps[$];
    int e_l0wr, e_ifwr, e_load, e_exec, e_osdr;
    // observed
    int act_rd[$], act_ps[$];
    int a_l0wr, a_ifwr, a_load, a_exec, a_osdr, a_done, a_viol, a_done_cyc;
    int a_first_rd, a_first_wr, a_first_l0rd;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_out_ones();
        return $countones({sram_rd_en, sram_addr, l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd,
                           inst, os_en_q, psum_wr_en, psum_addr, busy, done});
    endfunction

    // Job-level model: which addresses get read, what lands where, what gets drained
    task automatic build_model(input vec_t v);
        exp_rd.delete(); exp_ps.delete();
        e_l0wr = 0; e_ifwr = 0; e_load = 0; e_exec = 0; e_osdr = 0;
        if (v.nv == 0 || (v.os && v.nv > DEPTH)) return;
        for (int k = 0; k < (v.os ? v.nv : COL); k++) exp_rd.push_back((v.wb + k) % AMOD);
        for (int k = 0; k < v.nv; k++) exp_rd.push_back((v.xb + k) % AMOD);
        for (int m = 0; m < (v.os ? ROW : v.nv); m++) exp_ps.push_back((v.pb + m) % AMOD);
        e_exec = v.nv;
        if (v.os) begin e_ifwr = v.nv; e_l0wr = v.nv; e_osdr = ROW; end
        else begin e_load = COL; e_l0wr = COL + v.nv; end
    endtask

    // Drive one job cycle by cycle (cycle 0 = start cycle) and observe the rules on the fly
    task automatic run_job(input vec_t v);
        int rd_n, wr_n, lrd_n, c, t0, nw;
        bit fin, rd_if, wr_if, full_rd, full_wr;
        rd_n = 0; wr_n = 0; lrd_n = 0; c = 0; t0 = -1; fin = 0;
        act_rd.delete(); act_ps.delete();
        a_l0wr = 0; a_ifwr = 0; a_load = 0; a_exec = 0; a_osdr = 0; a_done = 0; a_viol = 0;
        a_done_cyc = -1; a_first_rd = -1; a_first_wr = -1; a_first_l0rd = -1;
        while (!fin) begin
            @(posedge clk); #1;
            start  = (c == 0) || (v.poke && a_done_cyc < 0 && (c == 4 || c == 30));
            os_en  = (c == 0) ? v.os : ~v.os;
            n_vec  = (c == 0) ? LBW'(v.nv) : LBW'(5);
            w_base = ABW'(c == 0 ? v.wb : 300);
            x_base = ABW'(c == 0 ? v.xb : 400);
            p_base = ABW'(c == 0 ? v.pb : 500);
            case (v.bp)
                1: begin
                    l0_full     = ($urandom_range(0, 3) == 0);
                    ififo_full  = ($urandom_range(0, 3) == 0);
                    ofifo_valid = ($urandom_range(0, 9) < 7);
                end
                2: begin
                    l0_full     = (t0 >= 0 && c >= t0 && c < t0 + 5);
                    ififo_full  = 1'b0;
                    ofifo_valid = 1'b1;
                end
                default: begin l0_full = 1'b0; ififo_full = 1'b0; ofifo_valid = 1'b1; end
            endcase
            @(negedge clk);
            rd_if   = v.os && (rd_n < v.nv);
            wr_if   = v.os && (wr_n < v.nv);
            full_rd = rd_if ? ififo_full : l0_full;
            full_wr = wr_if ? ififo_full : l0_full;
            nw      = int'(l0_wr) + int'(ififo_wr);
            // writes: only with data pending, never into a full target, never late
            if (nw > 1) a_viol++;
            if (nw == 1) begin
                if (rd_n - wr_n <= 0) a_viol++;
                if (full_wr) a_viol++;
                if (ififo_wr != wr_if) a_viol++;
                if (a_first_wr < 0) a_first_wr = c;
            end else if (rd_n - wr_n > 0 && !full_wr) a_viol++;
            // reads: target not full, nothing held back
            if (sram_rd_en) begin
                if (full_rd) a_viol++;
                if (rd_n - (wr_n + nw) > 0) a_viol++;
                act_rd.push_back(int'(sram_addr));
                if (a_first_rd < 0) a_first_rd = c;
                rd_n++;
            end
            // L0 reads trail L0 writes; inst follows the phase of each read
            if (l0_rd) begin
                if (lrd_n >= a_l0wr) a_viol++;
                if (!v.os && lrd_n < COL) begin if (inst !== 2'b01) a_viol++; a_load++; end
                else begin if (inst !== 2'b10) a_viol++; a_exec++; end
                if (a_first_l0rd < 0) a_first_l0rd = c;
                lrd_n++;
            end else if (inst === 2'b01) a_osdr++;
            else if (inst !== 2'b00) a_viol++;
            if (ififo_rd !== (v.os ? l0_rd : 1'b0)) a_viol++;
            if (psum_wr_en !== ofifo_rd) a_viol++;
            if (ofifo_rd && !ofifo_valid) a_viol++;
            if (ofifo_rd) act_ps.push_back(int'(psum_addr));
            if (done) begin
                a_done++;
                if (a_done_cyc < 0) a_done_cyc = c;
                if (busy) a_viol++;
            end
            if (c == 0 && busy) a_viol++;
            if (c >= 1 && a_done_cyc < 0) begin
                if (!busy) a_viol++;
                if (os_en_q !== v.os) a_viol++;
            end
            if (a_done_cyc >= 0 && c > a_done_cyc && busy) a_viol++;
            a_l0wr += int'(l0_wr);
            a_ifwr += int'(ififo_wr);
            wr_n   += nw;
            if (!v.os && v.bp == 2 && t0 < 0 && rd_n == COL + 4) t0 = c + 1;
            c++;
            if (a_done_cyc >= 0 && c > a_done_cyc + 3) fin = 1;
            if (c > 3000) begin chk("job_timeout", c, 0); fin = 1; end
        end
        start = 1'b0; l0_full = 1'b0; ififo_full = 1'b0; ofifo_valid = 1'b0;
    endtask

    task automatic check_job(input string tag, input vec_t v);
        int mm;
        chk({tag, "_done_count"}, a_done, 1);
        chk({tag, "_rule_violations"}, a_viol, 0);
        chk({tag, "_sram_reads"}, act_rd.size(), exp_rd.size());
        mm = -1;
        for (int i = 0; i < act_rd.size() && i < exp_rd.size(); i++)
            if (mm < 0 && act_rd[i] != exp_rd[i]) mm = i;
        chk({tag, "_rd_addr_first_bad_idx"}, mm, -1);
        chk({tag, "_psum_writes"}, act_ps.size(), exp_ps.size());
        mm = -1;
        for (int i = 0; i < act_ps.size() && i < exp_ps.size(); i++)
            if (mm < 0 && act_ps[i] != exp_ps[i]) mm = i;
        chk({tag, "_psum_addr_first_bad_idx"}, mm, -1);
        chk({tag, "_l0_wr"}, a_l0wr, e_l0wr);
        chk({tag, "_ififo_wr"}, a_ifwr, e_ifwr);
        chk({tag, "_load_reads"}, a_load, e_load);
        chk({tag, "_exec_reads"}, a_exec, e_exec);
        chk({tag, "_osdrain_cycles"}, a_osdr, e_osdr);
        if (v.psum_n >= 0) chk({tag, "_psum_count"}, act_ps.size(), v.psum_n);
        if (v.done_cyc >= 0) chk({tag, "_done_cycle"}, a_done_cyc, v.done_cyc);
        if (v.bp == 0 && v.nv > 0 && !(v.os && v.nv > DEPTH)) begin
            chk({tag, "_first_rd_cycle"}, a_first_rd, 1);
            chk({tag, "_first_wr_cycle"}, a_first_wr, 2);
            if (!v.os) chk({tag, "_first_l0rd_cycle"}, a_first_l0rd, 3);
        end
    endtask

    initial begin
        vec_t rv;
        int cnt;
        tbl[0] = '{0, 16,    0,  64,  128, 0, 0, -1, 16};
        tbl[1] = '{1,  8,   16,  40,  300, 0, 0, -1,  8};
        tbl[2] = '{0, 16,    0,  64,  128, 2, 0, -1, 16};
        tbl[3] = '{0,  0,    5,   6,    7, 0, 0,  2,  0};
        tbl[4] = '{1,  0,    5,   6,    7, 0, 0,  2,  0};
        tbl[5] = '{1, 200,   5,   6,    7, 0, 0,  1,  0};
        tbl[6] = '{0,  3, 2045,  10, 2046, 1, 1, -1,  3};
        tbl[7] = '{1, 128, 100, 500, 2000, 1, 0, -1,  8};

        // asynchronous reset with stimulus toggling
        #2 reset = 1'b0;
        start = 1'b1; ofifo_valid = 1'b1;
        #1 chk("reset_outputs_zero", all_out_ones(), 0);
        #20 chk("reset_outputs_held", all_out_ones(), 0);
        start = 1'b0; ofifo_valid = 1'b0;
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            build_model(tbl[i]);
            run_job(tbl[i]);
            check_job($sformatf("tbl%0d", i), tbl[i]);
        end

        for (int i = 0; i < 10; i++) begin
            rv = '{bit'($urandom_range(0, 1)), $urandom_range(1, 24), $urandom_range(0, AMOD - 1),
                   $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1), 1,
                   bit'($urandom_range(0, 1)), -1, -1};
            build_model(rv);
            run_job(rv);
            check_job($sformatf("rnd%0d", i), rv);
        end

        // reset asserted mid-drain clears everything at once
        @(posedge clk); #1;
        start = 1'b1; os_en = 1'b0; n_vec = LBW'(4);
        w_base = ABW'(1); x_base = ABW'(2); p_base = ABW'(3); ofifo_valid = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        while (!psum_wr_en && cnt < 300) begin @(posedge clk); #1; cnt++; end
        chk("rst_drain_reached", int'(psum_wr_en), 1);
        reset = 1'b0;
        #1 chk("rst_drain_outputs_zero", all_out_ones(), 0);
        @(posedge clk); #1 chk("rst_drain_outputs_stay_zero", all_out_ones(), 0);
        ofifo_valid = 1'b0;
        @(negedge clk) reset = 1'b1;
        rv = '{0, 5, 700, 800, 900, 0, 0, -1, 5};
        build_model(rv);
        run_job(rv);
        check_job("after_reset", rv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
